// File: rtl/lsu_access_ctrl.sv
// MEM-stage load/store sequencer: splits byte/half/word accesses into aligned word beats.
// Build option LSU_MISALIGN_SPLIT_EN: when defined, word-crossing accesses issue two beats instead of being refused.
module lsu_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_sl_sel,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misaligned,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t state;

  logic              valid_in, cross_in, refuse_in;
  logic [2:0]        size_in;
  logic [3:0]        smask_in;
  logic [2*DATA_W-1:0] sh_data_in;
  logic [7:0]        sh_mask_in;

  logic              we_q, cross_q;
  logic [2:0]        sel_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] wdata_hi_q, w0_q;
  logic [3:0]        mask_hi_q;

  always_comb begin
    valid_in = 1'b1;
    size_in  = 3'd1;
    smask_in = 4'b0001;
    case (i_sl_sel)
      3'b001, 3'b100: begin size_in = 3'd1; smask_in = 4'b0001; end
      3'b010, 3'b101: begin size_in = 3'd2; smask_in = 4'b0011; end
      3'b011:         begin size_in = 3'd4; smask_in = 4'b1111; end
      default:        valid_in = 1'b0;
    endcase
    cross_in  = ({1'b0, i_addr[1:0]} + size_in) > 3'd4;
    refuse_in = cross_in && !SPLIT_EN;
  end

  // Both beats' lanes come from one 64-bit shift; the high half is kept for BEAT1.
  assign sh_data_in = {{DATA_W{1'b0}}, i_wdata} << {i_addr[1:0], 3'b000};
  assign sh_mask_in = {4'b0000, smask_in} << i_addr[1:0];

  assign o_busy = (state != IDLE) || (i_req && i_reset);

  function automatic logic [31:0] merge(input logic [63:0] d, input logic [1:0] off,
                                        input logic [2:0] sel);
    logic [31:0] s;
    s = 32'(d >> {off, 3'b000});
    case (sel)
      3'b001:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b010:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      o_done       <= 1'b0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_bmask  <= '0;
      we_q         <= 1'b0;
      cross_q      <= 1'b0;
      sel_q        <= '0;
      off_q        <= '0;
      wdata_hi_q   <= '0;
      mask_hi_q    <= '0;
      w0_q         <= '0;
    end else begin
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        IDLE: if (i_req) begin
          we_q       <= i_we;
          sel_q      <= i_sl_sel;
          off_q      <= i_addr[1:0];
          cross_q    <= cross_in;
          wdata_hi_q <= sh_data_in[2*DATA_W-1:DATA_W];
          mask_hi_q  <= sh_mask_in[7:4];
          if (!valid_in || refuse_in) begin
            state        <= DONE;
            o_done       <= 1'b1;
            o_rdata      <= '0;
            o_misaligned <= valid_in && refuse_in;
          end else begin
            state       <= BEAT0;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_we;
            o_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            o_mem_wdata <= i_we ? sh_data_in[DATA_W-1:0] : '0;
            o_mem_bmask <= i_we ? sh_mask_in[3:0] : 4'b0000;
          end
        end
        BEAT0: if (i_mem_ack) begin
          w0_q <= i_mem_rdata;
          if (cross_q) begin
            // Request stays up; only the address and lanes move to the next word.
            state       <= BEAT1;
            o_mem_addr  <= o_mem_addr + ADDR_W'(4);
            o_mem_wdata <= we_q ? wdata_hi_q : '0;
            o_mem_bmask <= we_q ? mask_hi_q : 4'b0000;
          end else begin
            state       <= DONE;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_bmask <= 4'b0000;
            o_done      <= 1'b1;
            o_rdata     <= we_q ? '0 : merge({32'd0, i_mem_rdata}, off_q, sel_q);
          end
        end
        BEAT1: if (i_mem_ack) begin
          state        <= DONE;
          o_mem_req    <= 1'b0;
          o_mem_we     <= 1'b0;
          o_mem_wdata  <= '0;
          o_mem_bmask  <= 4'b0000;
          o_done       <= 1'b1;
          o_misaligned <= 1'b1;
          o_rdata      <= we_q ? '0 : merge({i_mem_rdata, w0_q}, off_q, sel_q);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Scoreboard bench for lsu_access_ctrl: a memory responder logs beats, tasks compare against queued expectations.
module tb_lsu_access_ctrl;
  logic        i_clk = 0, i_reset = 0, i_req = 0, i_we = 0;
  logic [2:0]  i_sl_sel = 0;
  logic [31:0] i_addr = 0, i_wdata = 0;
  logic        o_busy, o_done, o_misaligned, o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack = 0;
  logic [31:0] i_mem_rdata = 0;

  always #5 i_clk = ~i_clk;

  lsu_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_sl_sel(i_sl_sel),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
    .o_misaligned(o_misaligned), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata));

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] bmask;} beat_t;
  typedef struct packed {logic [31:0] rdata; logic mis; logic [7:0] lat;} res_t;

  beat_t exp_beats[$], obs_beats[$];
  res_t  exp_res[$];
  logic [31:0] mem [logic [31:0]];
  int n_cmp = 0, n_bad = 0, ack_delay = 0, wait_cnt = 0, stab_err = 0;
  bit resp_en = 1, man_ack = 0;
  beat_t cur;

  // Memory responder: acks after ack_delay waiting cycles, checks the beat stays stable meanwhile.
  always @(negedge i_clk) begin
    beat_t now;
    now = {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask};
    if (!resp_en) begin
      i_mem_ack = man_ack;
    end else if (o_mem_req) begin
      if (wait_cnt == 0) cur = now;
      else if (cur !== now) stab_err++;
      if (wait_cnt >= ack_delay) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem.exists(now.addr) ? mem[now.addr] : 32'h0;
        if (now.we) begin
          logic [31:0] w;
          w = mem.exists(now.addr) ? mem[now.addr] : 32'h0;
          for (int b = 0; b < 4; b++) if (now.bmask[b]) w[b*8 +: 8] = now.wdata[b*8 +: 8];
          mem[now.addr] = w;
        end
        obs_beats.push_back(now);
        wait_cnt = 0;
      end else begin
        i_mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic run_access(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata, output res_t r, output int busy_low,
                            output logic busy_acc);
    int lat;
    bit done;
    @(negedge i_clk);
    i_req = 1; i_we = we; i_sl_sel = sel; i_addr = addr; i_wdata = wdata;
    #1 busy_acc = o_busy;
    @(posedge i_clk);
    #1 i_req = 0;
    lat = 1; busy_low = 0; done = 0; r = '0;
    while (!done && lat < 40) begin
      @(negedge i_clk);
      lat++;
      if (!o_busy) busy_low++;
      if (o_done) begin
        done = 1; r.rdata = o_rdata; r.mis = o_misaligned;
      end
    end
    r.lat = done ? 8'(lat) : 8'hFF;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({o_busy, o_done, o_rdata, o_misaligned, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
         o_mem_bmask} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b rdata=%h mis=%b req=%b addr=%h, want all 0",
               o_busy, o_done, o_rdata, o_misaligned, o_mem_req, o_mem_addr);
    end
    @(negedge i_clk);
    i_reset = 1;
  endtask

  task automatic test_aligned_lw();
    res_t r, e;
    int bl;
    logic ba;
    mem[32'h100] = 32'h8899AABB;
    ack_delay = 0;
    exp_beats.push_back({1'b0, 32'h100, 32'h0, 4'h0});
    exp_res.push_back({32'h8899AABB, 1'b0, 8'd3});
    run_access(0, 3'b011, 32'h100, 0, r, bl, ba);
    n_cmp++;
    if (ba !== 1'b1) begin n_bad++; $display("FAIL lw_busy_on_accept: got %b want 1", ba); end
    while (exp_beats.size() > 0) begin
      beat_t eb, ob;
      eb = exp_beats.pop_front(); n_cmp++;
      if (obs_beats.size() == 0) begin n_bad++; $display("FAIL lw_beat: got none want %h", eb); end
      else begin
        ob = obs_beats.pop_front();
        if (ob !== eb) begin n_bad++; $display("FAIL lw_beat: got %h want %h", ob, eb); end
      end
    end
    e = exp_res.pop_front(); n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL lw_result: got %h want %h", r, e); end
  endtask

  task automatic test_extend();
    logic [2:0]  sel [4] = '{3'b001, 3'b100, 3'b010, 3'b101};
    logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h101};
    logic [31:0] exd [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000FFFF};
    mem[32'h100] = 32'h80FFFFFF;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      res_t r, e;
      int bl;
      logic ba;
      exp_beats.push_back({1'b0, 32'h100, 32'h0, 4'h0});
      exp_res.push_back({exd[i], 1'b0, 8'd3});
      run_access(0, sel[i], adr[i], 0, r, bl, ba);
      while (exp_beats.size() > 0) begin
        beat_t eb, ob;
        eb = exp_beats.pop_front(); n_cmp++;
        if (obs_beats.size() == 0) begin n_bad++; $display("FAIL ext%0d_beat: got none want %h", i, eb); end
        else begin
          ob = obs_beats.pop_front();
          if (ob !== eb) begin n_bad++; $display("FAIL ext%0d_beat: got %h want %h", i, ob, eb); end
        end
      end
      e = exp_res.pop_front(); n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL ext%0d_result: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_split_lw();
    res_t r, e;
    int bl;
    logic ba;
    mem[32'h100] = 32'h11223344;
    mem[32'h104] = 32'h55667788;
    ack_delay = 0;
    if (SPLIT) begin
      exp_beats.push_back({1'b0, 32'h100, 32'h0, 4'h0});
      exp_beats.push_back({1'b0, 32'h104, 32'h0, 4'h0});
      exp_res.push_back({32'h77881122, 1'b1, 8'd4});
    end else begin
      exp_res.push_back({32'h0, 1'b1, 8'd2});
    end
    run_access(0, 3'b011, 32'h102, 0, r, bl, ba);
    while (exp_beats.size() > 0) begin
      beat_t eb, ob;
      eb = exp_beats.pop_front(); n_cmp++;
      if (obs_beats.size() == 0) begin n_bad++; $display("FAIL split_lw_beat: got none want %h", eb); end
      else begin
        ob = obs_beats.pop_front();
        if (ob !== eb) begin n_bad++; $display("FAIL split_lw_beat: got %h want %h", ob, eb); end
      end
    end
    n_cmp++;
    if (obs_beats.size() != 0) begin
      n_bad++; $display("FAIL split_lw_extra_beats: got %0d want 0", obs_beats.size());
      obs_beats.delete();
    end
    e = exp_res.pop_front(); n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL split_lw_result: got %h want %h", r, e); end
  endtask

  task automatic test_split_sw_wrap();
    res_t r, e;
    int bl;
    logic ba;
    ack_delay = 0;
    if (SPLIT) begin
      exp_beats.push_back({1'b1, 32'hFFFFFFFC, 32'hCCDD0000, 4'b1100});
      exp_beats.push_back({1'b1, 32'h00000000, 32'h0000AABB, 4'b0011});
      exp_res.push_back({32'h0, 1'b1, 8'd4});
    end else begin
      exp_res.push_back({32'h0, 1'b1, 8'd2});
    end
    run_access(1, 3'b011, 32'hFFFFFFFE, 32'hAABBCCDD, r, bl, ba);
    while (exp_beats.size() > 0) begin
      beat_t eb, ob;
      eb = exp_beats.pop_front(); n_cmp++;
      if (obs_beats.size() == 0) begin n_bad++; $display("FAIL sw_wrap_beat: got none want %h", eb); end
      else begin
        ob = obs_beats.pop_front();
        if (ob !== eb) begin n_bad++; $display("FAIL sw_wrap_beat: got %h want %h", ob, eb); end
      end
    end
    n_cmp++;
    if (obs_beats.size() != 0) begin
      n_bad++; $display("FAIL sw_wrap_extra_beats: got %0d want 0", obs_beats.size());
      obs_beats.delete();
    end
    e = exp_res.pop_front(); n_cmp++;
    if ({r.mis, r.lat} !== {e.mis, e.lat}) begin
      n_bad++; $display("FAIL sw_wrap_done: got mis=%b lat=%0d want mis=%b lat=%0d", r.mis, r.lat, e.mis, e.lat);
    end
  endtask

  task automatic test_stall_sh();
    res_t r, e;
    int bl;
    logic ba;
    ack_delay = 3;
    stab_err  = 0;
    exp_beats.push_back({1'b1, 32'h200, 32'h00123400, 4'b0110});
    exp_res.push_back({32'h0, 1'b0, 8'd6});
    run_access(1, 3'b010, 32'h201, 32'h00001234, r, bl, ba);
    ack_delay = 0;
    while (exp_beats.size() > 0) begin
      beat_t eb, ob;
      eb = exp_beats.pop_front(); n_cmp++;
      if (obs_beats.size() == 0) begin n_bad++; $display("FAIL sh_stall_beat: got none want %h", eb); end
      else begin
        ob = obs_beats.pop_front();
        if (ob !== eb) begin n_bad++; $display("FAIL sh_stall_beat: got %h want %h", ob, eb); end
      end
    end
    n_cmp++;
    if (stab_err != 0) begin n_bad++; $display("FAIL sh_stall_stable: got %0d changes want 0", stab_err); end
    n_cmp++;
    if (bl != 0) begin n_bad++; $display("FAIL sh_stall_busy: got %0d low cycles want 0", bl); end
    e = exp_res.pop_front(); n_cmp++;
    if ({r.mis, r.lat} !== {e.mis, e.lat}) begin
      n_bad++; $display("FAIL sh_stall_done: got mis=%b lat=%0d want mis=%b lat=%0d", r.mis, r.lat, e.mis, e.lat);
    end
  endtask

  task automatic test_invalid();
    logic [2:0] sel [3] = '{3'b000, 3'b110, 3'b111};
    for (int i = 0; i < 3; i++) begin
      res_t r, e;
      int bl;
      logic ba;
      exp_res.push_back({32'h0, 1'b0, 8'd2});
      run_access(0, sel[i], 32'h100, 0, r, bl, ba);
      n_cmp++;
      if (obs_beats.size() != 0) begin
        n_bad++; $display("FAIL invalid%0d_beats: got %0d want 0", i, obs_beats.size());
        obs_beats.delete();
      end
      e = exp_res.pop_front(); n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL invalid%0d_result: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_reset_midbeat();
    res_t r, e;
    int bl;
    logic ba;
    resp_en = 0; man_ack = 0;
    @(negedge i_clk);
    i_req = 1; i_we = 0; i_sl_sel = 3'b011; i_addr = SPLIT ? 32'h102 : 32'h100;
    @(posedge i_clk);
    #1 i_req = 0; man_ack = SPLIT;
    @(negedge i_clk);
    n_cmp++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h100}) begin
      n_bad++; $display("FAIL rst_beat0: got req=%b addr=%h want 1/00000100", o_mem_req, o_mem_addr);
    end
    @(posedge i_clk);
    #1 man_ack = 0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, SPLIT ? 32'h104 : 32'h100}) begin
      n_bad++; $display("FAIL rst_second_cycle: got req=%b addr=%h", o_mem_req, o_mem_addr);
    end
    #2 i_reset = 0;
    #1;
    n_cmp++;
    if ({o_mem_req, o_busy, o_done} !== 3'b000) begin
      n_bad++; $display("FAIL rst_async_drop: got req/busy/done=%b%b%b want 000", o_mem_req, o_busy, o_done);
    end
    @(posedge i_clk);
    #1 man_ack = 1;
    @(negedge i_clk);
    #1 i_reset = 1;
    @(posedge i_clk);
    #1 man_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_cmp++;
      if ({o_mem_req, o_busy, o_done} !== 3'b000) begin
        n_bad++; $display("FAIL rst_late_ack%0d: got req/busy/done=%b%b%b want 000", i, o_mem_req, o_busy, o_done);
      end
    end
    wait_cnt = 0; resp_en = 1;
    mem[32'h300] = 32'hCAFEF00D;
    exp_beats.push_back({1'b0, 32'h300, 32'h0, 4'h0});
    exp_res.push_back({32'hCAFEF00D, 1'b0, 8'd3});
    run_access(0, 3'b011, 32'h300, 0, r, bl, ba);
    while (exp_beats.size() > 0) begin
      beat_t eb, ob;
      eb = exp_beats.pop_front(); n_cmp++;
      if (obs_beats.size() == 0) begin n_bad++; $display("FAIL post_rst_beat: got none want %h", eb); end
      else begin
        ob = obs_beats.pop_front();
        if (ob !== eb) begin n_bad++; $display("FAIL post_rst_beat: got %h want %h", ob, eb); end
      end
    end
    n_cmp++;
    if (obs_beats.size() != 0) begin
      n_bad++; $display("FAIL post_rst_extra_beats: got %0d want 0", obs_beats.size());
      obs_beats.delete();
    end
    e = exp_res.pop_front(); n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL post_rst_result: got %h want %h", r, e); end
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_extend();
    test_split_lw();
    test_split_sw_wrap();
    test_stall_sh();
    test_invalid();
    test_reset_midbeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
